// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesting agents and the round-robin arbiter.
// The master side drives enable and requests; the slave side (arbiter) drives the grant.
interface rr_arbiter_4_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a per-owner hold quantum and a registered
// one-hot grant that can drive a resource select directly.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_arbiter_4_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] cur_reg, cur_next;
    logic [1:0] last_reg, last_next;
    logic [3:0] hold_cnt_reg, hold_cnt_next;
    logic [3:0] gnt_reg, gnt_next;
    logic [1:0] gnt_idx_reg, gnt_idx_next;
    logic       gnt_valid_reg, gnt_valid_next;

    // Candidates in scan order starting just after the most recent owner.
    logic [1:0] cand [4];
    logic [3:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi]     = last_reg + 2'(gi + 1);
            assign cand_hit[gi] = bus.req[cand[gi]];
        end
    endgenerate

    logic       win_valid;
    logic [1:0] win_idx;

    always_comb begin
        win_valid = |bus.req;
        win_idx   = cand[0];
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_idx = cand[k];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;

        if (!bus.en) begin
            state_next    = IDLE;
            hold_cnt_next = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        state_next    = GRANT;
                        cur_next      = win_idx;
                        last_next     = win_idx;
                        hold_cnt_next = 4'd1;
                    end
                end
                GRANT: begin
                    if (bus.req[cur_reg] && (hold_cnt_reg < 4'(MAX_HOLD))) begin
                        hold_cnt_next = hold_cnt_reg + 4'd1;
                    end else if (win_valid) begin
                        // Direct handoff; may re-grant cur when it is the only requester.
                        cur_next      = win_idx;
                        last_next     = win_idx;
                        hold_cnt_next = 4'd1;
                    end else begin
                        state_next    = IDLE;
                        hold_cnt_next = 4'd0;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    hold_cnt_next = 4'd0;
                end
            endcase
        end

        gnt_valid_next = (state_next == GRANT);
        gnt_idx_next   = gnt_valid_next ? cur_next : 2'b00;
        gnt_next       = gnt_valid_next ? (4'b0001 << cur_next) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_reg       <= 2'b00;
            last_reg      <= 2'b11;
            hold_cnt_reg  <= 4'd0;
            gnt_reg       <= 4'b0000;
            gnt_idx_reg   <= 2'b00;
            gnt_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            last_reg      <= last_next;
            hold_cnt_reg  <= hold_cnt_next;
            gnt_reg       <= gnt_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= gnt_valid_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_idx   = gnt_idx_reg;
    assign bus.gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: reset, rotation, early handoff, sole requester,
// enable drop and asynchronous reset mid-grant.
module tb_rr_arbiter_4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] exp_gnt,
                             input logic [1:0] exp_idx, input logic exp_valid);
        check({tag, ".gnt"}, bus.gnt, exp_gnt);
        check({tag, ".idx"}, {2'b00, bus.gnt_idx}, {2'b00, exp_idx});
        check({tag, ".valid"}, {3'b000, bus.gnt_valid}, {3'b000, exp_valid});
        $display("step %-12s req=%b en=%b gnt=%b idx=%0d valid=%b",
                 tag, bus.req, bus.en, bus.gnt, bus.gnt_idx, bus.gnt_valid);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [3:0] rot_exp;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 4'b0000;

        // Reset state
        step();
        step();
        check_all("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;

        // Single request and drop
        bus.en  = 1'b1;
        bus.req = 4'b0100;
        step();
        check_all("single", 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b0000;
        step();
        check_all("drop", 4'b0000, 2'd0, 1'b0);

        // Rotation with all four requesting from reset pointer
        pulse_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            step();
            rot_exp = 4'b0001 << ((i / 4) % 4);
            check_all($sformatf("rot%0d", i), rot_exp, 2'((i / 4) % 4), 1'b1);
        end

        // Early release handoff from owner 0 to 1
        pulse_reset();
        bus.req = 4'b0011;
        step();
        check_all("early0a", 4'b0001, 2'd0, 1'b1);
        step();
        check_all("early0b", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b0010;
        step();
        check_all("handoff", 4'b0010, 2'd1, 1'b1);
        // Hold count restarted: owner 1 gets three more cycles before rotating.
        bus.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("hold1_%0d", i), 4'b0010, 2'd1, 1'b1);
        end
        step();
        check_all("rot_back0", 4'b0001, 2'd0, 1'b1);

        // Sole requester past quantum keeps the grant
        bus.req = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            step();
            check_all($sformatf("sole%0d", i), 4'b1000, 2'd3, 1'b1);
        end

        // Enable low mid-grant, pointer retained
        bus.req = 4'b0010;
        step();
        check_all("own1", 4'b0010, 2'd1, 1'b1);
        bus.en = 1'b0;
        step();
        check_all("en_low", 4'b0000, 2'd0, 1'b0);
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        step();
        check_all("en_back", 4'b0100, 2'd2, 1'b1);

        // Asynchronous reset between edges clears outputs immediately
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 2'd0, 1'b0);
        #1;
        rst_n   = 1'b1;
        bus.req = 4'b1010;
        step();
        check_all("after_rst", 4'b0010, 2'd1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

- Round-robin arbiter that shares one resource among four requesters.
- Output is a registered one-hot grant vector in the same form a 2-to-4 decoder with enable produces, so it drives the resource's select lines directly.
- Holds each grant while the owner keeps requesting, up to a programmable quantum, then rotates priority.
- Sits between requesting agents and the shared datapath or bus select.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per owner. Legal range 1..15.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `en` input, 1 bit: arbiter enable. Low forces IDLE and clears the grant on the next edge.
- `req` input, 4 bits: request lines; `req[i]` high means requester i wants the resource.
- `gnt` output, 4 bits: one-hot grant, registered; all zeros when no owner.
- `gnt_idx` output, 2 bits: binary index of the current owner; 0 when `gnt_valid` is low.
- `gnt_valid` output, 1 bit: high when `gnt` is non-zero.

## Operation
- **State:**
  - FSM with states IDLE and GRANT.
  - 2-bit owner register `cur`.
  - 2-bit priority pointer `last`, the most recently granted index.
  - Hold counter `hold_cnt`, 4 bits wide.
- **Reset (`rst_n` low, asynchronous):**
  - State goes to IDLE.
  - `gnt`=4'b0000, `gnt_idx`=2'b00, `gnt_valid`=0, `hold_cnt`=0.
  - `last`=2'b11, so index 0 has highest priority first.
- **Selection function:**
  - Scan indices `last+1`, `last+2`, `last+3`, `last+4`, all mod 4.
  - The first index with `req` high wins.
  - Wrap-around is natural 2-bit overflow: 3+1 gives 0.
- **IDLE:**
  - Condition: `en` high and `req` non-zero.
  - Action: go to GRANT, `cur` = winner, `last` = winner, `hold_cnt` = 1, `gnt` = one-hot of winner.
  - Otherwise stay in IDLE with `gnt`=0.
- **GRANT, per cycle:**
  - **Continue:** `req[cur]` high and `hold_cnt` < `MAX_HOLD`.
    - Keep `cur` and increment `hold_cnt`.
  - **Release:** `req[cur]` low, or `hold_cnt` == `MAX_HOLD`.
    - Run selection from `last` (= `cur`).
    - If a winner exists, hand off directly with no idle cycle: `cur` = winner, `last` = winner, `hold_cnt` = 1.
    - The winner equals `cur` only when `cur` is the sole requester with quantum expired; it is then re-granted with the count reset.
    - If there is no winner, go to IDLE and set `gnt`=0.
- **`en` low:**
  - Overrides everything on the next edge: go to IDLE, `gnt`=0, `hold_cnt`=0.
  - `last` is retained, so rotation resumes fairly when `en` returns high.
- **Grant encoding:** `gnt` always equals the decode of `gnt_idx` gated by `gnt_valid`. It is never multi-hot.
- **Simultaneous requests:** resolved only by the pointer; no fixed priority exists beyond reset.

## Timing
- **Grant latency:** `req` sampled at edge N gives `gnt` valid after edge N (one cycle, registered). No combinational path from `req` to `gnt`.
- **Release latency:**
  - `req[cur]` dropped before edge N gives the new grant or zero after edge N.
  - The owner sees its grant for at most one cycle after it deasserts.
- **Quantum:** a continuous requester holds `gnt` for exactly `MAX_HOLD` cycles when others are waiting.
- **Worst-case wait:** 3 × `MAX_HOLD` cycles from request to grant with all four requesting.
- **Mid-grant reset:** `rst_n` falling clears outputs immediately, without waiting for a clock edge. The first grant after reset goes to the lowest-index requester.
- **Glitch-free outputs:** `gnt`, `gnt_idx` and `gnt_valid` change only on `clk` edges or on asynchronous reset assertion.

## Test plan
- **Reset and single request:** reset, `en`=1, `req`=4'b0100 → one cycle later `gnt`=4'b0100, `gnt_idx`=2, `gnt_valid`=1. Drop `req` → next edge `gnt`=4'b0000.
- **Rotation:** `MAX_HOLD`=4, `req`=4'b1111 held → `gnt` sequence 0001 ×4, 0010 ×4, 0100 ×4, 1000 ×4, 0001, …, with no gap cycles.
- **Early release handoff:** `req`=4'b0011 with owner 0; drop `req[0]` after 2 grant cycles → next edge `gnt`=4'b0010 directly, `hold_cnt` restarts.
- **Sole requester past quantum:** `req`=4'b1000 for 10 cycles → `gnt`=4'b1000 continuously, `gnt_valid` never drops.
- **Enable low mid-grant:** owner 1 granted, `en`=0 → next edge `gnt`=0. Restore `en`=1 with `req`=4'b1111 → grant goes to index 2, since `last`=1 is preserved.
- **Async reset mid-grant:** pulse `rst_n` low between edges while `gnt`=4'b0100 → outputs are 0 immediately. After release with `req`=4'b1010 → grant 4'b0010.
